// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of reg_file_mp: operand reads, ALU write, load write, load issue.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int NRD    = 2
);
    localparam int ADDR_W = $clog2(NREG);

    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  ld_en;
    logic [ADDR_W-1:0]     ld_addr;
    logic [DATA_W-1:0]     ld_data;
    logic                  ld_ready;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data, iss_en, iss_addr,
        input  rd_data, rd_busy, ld_ready
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data, iss_en, iss_addr,
        output rd_data, rd_busy, ld_ready
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: ALU write port A, load write port B with one-entry collision hold,
// pending-load scoreboard. Define REG_BYPASS_EN to forward same-edge writes to the read ports.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int NRD    = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREG);

    typedef enum logic { EMPTY, FULL } hold_st_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ld_req_t;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0]             busy;
    hold_st_t                    st, st_nxt;
    ld_req_t                     hold, ld_in, lw;
    logic                        a_act, b_acc, b_coll, drain, lw_en;
    logic [NRD-1:0][DATA_W-1:0]  rd_d;
    logic [NRD-1:0]              rd_b;

    // R0 is filtered here so neither the array, the hold buffer nor busy ever sees it.
    assign a_act        = bus.wr_en && (bus.wr_addr != '0) && !reset;
    assign bus.ld_ready = (st == EMPTY);
    assign b_acc        = bus.ld_en && bus.ld_ready && (bus.ld_addr != '0) && !reset;
    assign ld_in        = {bus.ld_addr, bus.ld_data};

    always_comb begin
        st_nxt = st;
        drain  = 1'b0;
        b_coll = 1'b0;
        case (st)
            EMPTY: if (b_acc && a_act && (bus.ld_addr == bus.wr_addr)) begin
                b_coll = 1'b1;
                st_nxt = FULL;
            end
            FULL: if (!reset && !(a_act && (hold.addr == bus.wr_addr))) begin
                drain  = 1'b1;
                st_nxt = EMPTY;
            end
            default: st_nxt = EMPTY;
        endcase
    end

    // Drain and direct load are exclusive: accepts only happen while the hold is empty.
    assign lw_en = drain || (b_acc && !b_coll);
    assign lw    = drain ? hold : ld_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= EMPTY;
            busy <= '0;
            for (int k = 0; k < NREG; k++) regs[k] <= DATA_W'(k);
        end else begin
            st <= st_nxt;
            if (b_coll) hold <= ld_in;
            if (a_act)  regs[bus.wr_addr] <= bus.wr_data;
            if (lw_en) begin
                regs[lw.addr] <= lw.data;
                busy[lw.addr] <= 1'b0;
            end
            if (bus.iss_en && (bus.iss_addr != '0)) busy[bus.iss_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic              b;
        assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
        always_comb begin
            d = regs[ra];
            b = busy[ra];
`ifdef REG_BYPASS_EN
            // Load wins over port A, matching which value the array holds after the edge.
            if (ra != '0) begin
                if (lw_en && (lw.addr == ra)) begin
                    d = lw.data;
                    if (!(bus.iss_en && (bus.iss_addr == ra))) b = 1'b0;
                end else if (a_act && (bus.wr_addr == ra)) begin
                    d = bus.wr_data;
                end
            end
`endif
        end
        assign rd_d[i] = d;
        assign rd_b[i] = b;
    end

    assign bus.rd_data = rd_d;
    assign bus.rd_busy = rd_b;
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed plan items then random traffic against a queue-based model.
module tb_reg_file_mp;
    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int NRD    = 2;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) bus ();
    reg_file_mp #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int addr; logic [DATA_W-1:0] data; } ld_t;
    typedef struct {
        logic [NRD*DATA_W-1:0] rd_data;
        logic [NRD-1:0]        rd_busy;
        logic                  ld_ready;
    } exp_t;

    logic [DATA_W-1:0] m_reg [NREG];
    bit                m_busy [NREG];
    ld_t               m_hold [$];
    bit                m_valid = 0;
    exp_t              sb_q [$];
    int                total = 0;
    int                bad = 0;

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts this cycle's outputs, then steps to the post-edge state.
    task automatic cycle(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                         input bit le, input int la, input logic [31:0] ldd,
                         input bit ie, input int ia, input int r0, input int r1);
        logic [DATA_W-1:0] nreg [NREG];
        bit   nbusy [NREG];
        bit   wrote [NREG];
        bit   loaded [NREG];
        ld_t  nhold [$];
        ld_t  h;
        bit   ready, a_act;
        exp_t e;
        int   a;
        @(negedge clk); #1;
        reset = rst;
        bus.wr_en = we;  bus.wr_addr = wa[ADDR_W-1:0];  bus.wr_data = wd;
        bus.ld_en = le;  bus.ld_addr = la[ADDR_W-1:0];  bus.ld_data = ldd;
        bus.iss_en = ie; bus.iss_addr = ia[ADDR_W-1:0];
        bus.rd_addr = {r1[ADDR_W-1:0], r0[ADDR_W-1:0]};
        nreg = m_reg; nbusy = m_busy; nhold = m_hold;
        for (int k = 0; k < NREG; k++) begin wrote[k] = 0; loaded[k] = 0; end
        ready = (m_hold.size() == 0);
        a_act = we && wa != 0;
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin nreg[k] = DATA_W'(k); nbusy[k] = 0; end
            nhold.delete();
        end else begin
            if (a_act) begin nreg[wa] = wd; wrote[wa] = 1; end
            if (!ready && !(a_act && m_hold[0].addr == wa)) begin
                h = nhold.pop_front();
                nreg[h.addr] = h.data; nbusy[h.addr] = 0;
                wrote[h.addr] = 1; loaded[h.addr] = 1;
            end else if (le && ready && la != 0) begin
                if (a_act && la == wa) begin
                    h.addr = la; h.data = ldd; nhold.push_back(h);
                end else begin
                    nreg[la] = ldd; nbusy[la] = 0; wrote[la] = 1; loaded[la] = 1;
                end
            end
            if (ie && ia != 0) nbusy[ia] = 1;
        end
        if (m_valid) begin
            e.ld_ready = ready;
            for (int p = 0; p < NRD; p++) begin
                a = (p == 0) ? r0 : r1;
                e.rd_data[p*DATA_W +: DATA_W] = m_reg[a];
                e.rd_busy[p] = m_busy[a];
`ifdef REG_BYPASS_EN
                if (!rst && a != 0 && wrote[a]) e.rd_data[p*DATA_W +: DATA_W] = nreg[a];
                if (!rst && loaded[a] && !(ie && ia == a)) e.rd_busy[p] = 1'b0;
`endif
            end
            sb_q.push_back(e);
        end
        m_reg = nreg; m_busy = nbusy; m_hold = nhold;
        if (rst) m_valid = 1;
    endtask

    task automatic idle(input int r0, input int r1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                dchk("sb_rd0_data", bus.rd_data[31:0], e.rd_data[31:0]);
                dchk("sb_rd1_data", bus.rd_data[63:32], e.rd_data[63:32]);
                dchk("sb_rd_busy", 32'(bus.rd_busy), 32'(e.rd_busy));
                dchk("sb_ld_ready", 32'(bus.ld_ready), 32'(e.ld_ready));
            end
        end
    end

    initial begin : stim
        int wa, la;
        reset = 1'b1;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.iss_en = 0; bus.iss_addr = '0; bus.rd_addr = '0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        for (int k = 0; k < NREG; k++) idle(k, NREG - 1 - k);
        idle(5, 0); #1;
        dchk("rst_r5", bus.rd_data[31:0], 32'd5);
        dchk("rst_r0", bus.rd_data[63:32], 32'd0);
        dchk("rst_ready", 32'(bus.ld_ready), 32'd1);

        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5); #1;
`ifdef REG_BYPASS_EN
        dchk("same_cyc_r5", bus.rd_data[31:0], 32'hDEADBEEF);
`else
        dchk("same_cyc_r5", bus.rd_data[31:0], 32'd5);
`endif
        idle(5, 5); #1;
        dchk("next_r5", bus.rd_data[31:0], 32'hDEADBEEF);

        cycle(0, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 3, 3);
        idle(3, 3); #1;
        dchk("coll_ready0", 32'(bus.ld_ready), 32'd0);
`ifndef REG_BYPASS_EN
        dchk("coll_r3_a", bus.rd_data[31:0], 32'h11);
`endif
        idle(3, 3); #1;
        dchk("coll_r3_b", bus.rd_data[31:0], 32'h22);
        dchk("coll_ready1", 32'(bus.ld_ready), 32'd1);

        cycle(0, 1, 3, 32'h33, 1, 3, 32'h44, 0, 0, 3, 3);
        cycle(0, 1, 3, 32'h55, 0, 0, 0, 0, 0, 3, 3); #1;
        dchk("hold_ready_a", 32'(bus.ld_ready), 32'd0);
        idle(3, 3); #1;
        dchk("hold_ready_b", 32'(bus.ld_ready), 32'd0);
`ifndef REG_BYPASS_EN
        dchk("hold_r3_a", bus.rd_data[31:0], 32'h55);
`endif
        idle(3, 3); #1;
        dchk("hold_r3_final", bus.rd_data[31:0], 32'h44);
        dchk("hold_ready_c", 32'(bus.ld_ready), 32'd1);

        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
        idle(7, 7); #1;
        dchk("iss_busy7", 32'(bus.rd_busy[0]), 32'd1);
        cycle(0, 0, 0, 0, 1, 7, 32'h99, 0, 0, 7, 7);
        idle(7, 7); #1;
        dchk("ld_r7", bus.rd_data[31:0], 32'h99);
        dchk("ld_busy7", 32'(bus.rd_busy[0]), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
        cycle(0, 0, 0, 0, 1, 7, 32'hAA, 1, 7, 7, 7);
        idle(7, 7); #1;
        dchk("set_wins_busy7", 32'(bus.rd_busy[0]), 32'd1);
        dchk("set_wins_r7", bus.rd_data[31:0], 32'hAA);

        cycle(0, 1, 0, 32'hFFFF, 1, 0, 32'h1234, 1, 0, 0, 0);
        idle(0, 0); #1;
        dchk("r0_data", bus.rd_data[31:0], 32'd0);
        dchk("r0_busy", 32'(bus.rd_busy[0]), 32'd0);
        dchk("r0_ready", 32'(bus.ld_ready), 32'd1);

        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 4);
        cycle(0, 1, 4, 32'h1, 1, 4, 32'h77, 0, 0, 9, 4);
        cycle(1, 1, 4, 32'h2, 0, 0, 0, 0, 0, 9, 4);
        idle(9, 4); #1;
        dchk("midrst_r9", bus.rd_data[31:0], 32'd9);
        dchk("midrst_busy9", 32'(bus.rd_busy[0]), 32'd0);
        dchk("midrst_ready", 32'(bus.ld_ready), 32'd1);
        idle(4, 4);
        idle(4, 4); #1;
        dchk("midrst_r4", bus.rd_data[31:0], 32'd4);

        for (int n = 0; n < 3000; n++) begin
            wa = int'($urandom_range(0, NREG - 1));
            la = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NREG - 1));
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 1) == 1, la, $urandom,
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 2) == 0) ? la : int'($urandom_range(0, NREG - 1)),
                  int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)));
        end

        idle(0, 0);
        @(negedge clk); #5;
        dchk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
